conv3x3_window_gen: RTL
=======================

// Module: conv3x3_window_gen
// PURPOSE
//  Receive-side counterpart of the max-pool output stream: accepts a raster-order, valid-qualified
//  pixel stream (one channel, IMAGE_WIDTH x IMAGE_WIDTH) and emits one zero-padded 3x3 window per
//  pixel, ready for the next block's conv3x3 MACs. One instance per channel; sits between
//  max_pooling2x2_base of block N and conv1 of block N+1.
// PARAMETERS
//  DATA_WIDTH   32  pixel width (fp32 bit pattern, never interpreted)
//  IMAGE_WIDTH  5   frame side W (post-pool); frame = W*W pixels, W >= 3
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  i_valid    in   1              i_data carries a pixel this cycle (no backpressure)
//  i_data     in   DATA_WIDTH     pixel, raster order, row 0 col 0 first
//  o_valid    out  1              o_window valid this cycle
//  o_window   out  9*DATA_WIDTH   tap (i,j) at [DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = pixel(r-1+i, c-1+j)
//  o_row      out  clog2(W)       centre row r of current window
//  o_col      out  clog2(W)       centre col c of current window
//  o_done     out  1              pulse with the last window (r=c=W-1) of a frame
//  o_busy     out  1              high in FLUSH; input ignored
//  o_overrun  out  1              sticky: i_valid seen while in FLUSH
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, shift register cleared. Reset wins over any input.
//  - Storage: raster shift register of 2W+3 taps; shifts on each accepted pixel or flush cycle.
//  - States: IDLE -(i_valid)-> FILL; FILL -(pixel index W reached & one more accepted)-> STREAM;
//    STREAM -(pixel W*W-1 accepted)-> FLUSH; FLUSH -(W+1 cycles done)-> IDLE.
//  - Input index p counts 0..W*W-1; accepted only in IDLE/FILL/STREAM with i_valid=1.
//  - Window for centre k = p-W-1 is registered the cycle after pixel p is accepted (p >= W+1);
//    latency = 1 clk from the enabling pixel. Gaps in i_valid produce identical gaps in o_valid.
//  - FLUSH: W+1 consecutive cycles, each shifts in a virtual zero and emits centres W*W-W-1..W*W-1;
//    o_valid=1 every FLUSH cycle. Exactly W*W windows per frame, none outside.
//  - Padding: taps with row r-1<0, r+1>W-1, col c-1<0 (c=0) or c+1>W-1 (c=W-1) forced to 0;
//    mask derived from o_row/o_col counters, so raster wrap between rows never leaks pixels.
//  - o_row/o_col advance col-first, wrap at W-1; both 0 after the last window.
//  - o_done coincides with the o_valid carrying centre (W-1,W-1). Next frame may start the cycle
//    after FLUSH exits (IDLE accepts i_valid same cycle).
//  - i_valid during FLUSH: pixel dropped, o_overrun set (cleared only by rst); frame output unaffected.
//  - Reset mid-frame: counters/state/shift register cleared; partial frame discarded, no o_done.
// CONFIGURATION
//  - Macro WINGEN_OVERRUN_CHECK_EN: defined -> o_overrun sticky flag as above.
//    Undefined -> o_overrun tied 0, no detection logic; dropping in FLUSH unchanged.
// STRUCTURE
//  - Package wingen_pkg: state enum {IDLE,FILL,STREAM,FLUSH}; functions taps_f(W)=2W+3,
//    cnt_w_f(W)=clog2(W*W); tap index constants for the 9 window positions.
//  - Sub-module raster_shift_reg (DATA_WIDTH, DEPTH=2W+3): enable-gated shift, sync clear,
//    exposes the 9 window taps. FSM, counters and border masking stay in the top.
// TESTING (W=5, pixel value = index+1)
//  1 rst held 3 clk -> all outputs 0; release with i_valid=0 -> stays IDLE, o_valid=0.
//  2 25 pixels back-to-back -> first o_valid 1 clk after 7th pixel, window (0,0)=[0,0,0,0,1,2,0,6,7];
//    centre (2,2)=[7,8,9,12,13,14,17,18,19]; 25 windows; last (4,4)=[19,20,0,24,25,0,0,0,0] with o_done.
//  3 same frame, i_valid 1-of-3 cycles -> identical window sequence, FLUSH still 6 contiguous cycles.
//  4 i_valid held through FLUSH -> those pixels dropped, o_overrun=1 (0 if macro undefined), 25 windows.
//  5 rst after 10 pixels, then full new frame -> no o_done for aborted frame, new frame matches test 2.
//  6 two frames, second starts cycle after FLUSH exit -> 50 windows, two o_done pulses, no overrun.

Source files
------------

// File: rtl/wingen_pkg.sv
// -----------------------------------------------------------------------------
// wingen_pkg
// Shared definitions for the 3x3 window generator:
//   state_t     : FSM states of the window generator
//   taps_f      : raster shift register depth for frame side W (2W+3)
//   cnt_w_f     : pixel index counter width for frame side W
//   tap_idx_f   : shift register position feeding window tap (i,j)
//   WIN_*       : slot numbers of the 9 window positions inside o_window
// -----------------------------------------------------------------------------
package wingen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   // Window slot numbers: slot s lives at o_window[DATA_WIDTH*s +: DATA_WIDTH].
   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;

   function automatic int taps_f(input int w);
      return 2 * w + 3;
   endfunction

   function automatic int cnt_w_f(input int w);
      return $clog2(w * w);
   endfunction

   // Position 0 holds the newest pixel p; the window centre p-W-1 sits at
   // position W+1, so tap (i,j) = pixel p-W-1+(i-1)*W+(j-1) sits at
   // position (2-i)*W + (2-j).
   function automatic int tap_idx_f(input int w, input int i, input int j);
      return (2 - i) * w + (2 - j);
   endfunction

endpackage

// File: rtl/raster_shift_reg.sv
// -----------------------------------------------------------------------------
// raster_shift_reg
// Enable-gated raster shift register of DEPTH = 2W+3 pixels with synchronous
// clear. Exposes the 9 positions that form a 3x3 window around the pixel
// that entered W+1 shifts ago.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high clear of all positions
//   i_en    in   shift one position this cycle
//   i_data  in   DATA_WIDTH pixel shifted into position 0
//   o_taps  out  9*DATA_WIDTH window taps, slot 3*i+j = tap (i,j), unmasked
// -----------------------------------------------------------------------------
module raster_shift_reg
   import wingen_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en,
   input  logic [DATA_WIDTH-1:0]   i_data,
   output logic [9*DATA_WIDTH-1:0] o_taps
);

   localparam int W = (DEPTH - 3) / 2;

   logic [DATA_WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_sr[k] <= '0;
         end
      end else if (i_en) begin
         r_sr[0] <= i_data;
         for (int k = 1; k < DEPTH; k++) begin
            r_sr[k] <= r_sr[k-1];
         end
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         assign o_taps[DATA_WIDTH*(3*gi+gj) +: DATA_WIDTH] = r_sr[tap_idx_f(W, gi, gj)];
      end
   end

endmodule

// File: rtl/conv3x3_window_gen.sv
// -----------------------------------------------------------------------------
// conv3x3_window_gen
// Turns a raster-order, valid-qualified single-channel pixel stream of a
// W x W frame into one zero-padded 3x3 window per pixel.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   i_valid    in   i_data carries a pixel (no backpressure)
//   i_data     in   DATA_WIDTH pixel, raster order
//   o_valid    out  o_window valid this cycle
//   o_window   out  9*DATA_WIDTH window, tap (i,j) at [DW*(3i+j) +: DW]
//   o_row      out  centre row of the current window
//   o_col      out  centre col of the current window
//   o_done     out  pulse with the last window of a frame
//   o_busy     out  high while flushing; input is ignored then
//   o_overrun  out  sticky: i_valid seen while flushing
// Configuration:
//   WINGEN_OVERRUN_CHECK_EN  defined   -> o_overrun detection enabled
//                            undefined -> o_overrun tied 0
// Handshake: i_valid has no ready; a pixel is taken on every cycle i_valid=1
// outside FLUSH. o_valid has no ready; a window is presented for exactly one
// cycle and must be consumed then.
// -----------------------------------------------------------------------------
module conv3x3_window_gen
   import wingen_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int IMAGE_WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_valid,
   input  logic [DATA_WIDTH-1:0]          i_data,
   output logic                           o_valid,
   output logic [9*DATA_WIDTH-1:0]        o_window,
   output logic [$clog2(IMAGE_WIDTH)-1:0] o_row,
   output logic [$clog2(IMAGE_WIDTH)-1:0] o_col,
   output logic                           o_done,
   output logic                           o_busy,
   output logic                           o_overrun
);

   localparam int W     = IMAGE_WIDTH;
   localparam int RW    = $clog2(W);
   localparam int CW    = cnt_w_f(W);
   localparam int DEPTH = taps_f(W);

   localparam logic [CW-1:0] C_ONE     = CW'(1);
   localparam logic [CW-1:0] P_FIRST   = CW'(W + 1);   // pixel that enables window (0,0)
   localparam logic [CW-1:0] P_LAST    = CW'(W * W - 1);
   localparam logic [CW-1:0] FL_LAST   = CW'(W);       // W+1 flush cycles: 0..W
   localparam logic [RW-1:0] RC_ONE    = RW'(1);
   localparam logic [RW-1:0] RC_EDGE   = RW'(W - 1);

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     r_fcnt;
   logic [RW-1:0]     r_row;
   logic [RW-1:0]     r_col;
   logic              r_valid;
   logic              r_done;

   logic              w_accept;
   logic              w_flush;
   logic              w_shift_en;
   logic [DATA_WIDTH-1:0] w_shift_data;
   logic [9*DATA_WIDTH-1:0] w_taps;
   logic [9*DATA_WIDTH-1:0] w_masked;
   logic [RW-1:0]     w_next_row;
   logic [RW-1:0]     w_next_col;
   logic              w_row_lo;
   logic              w_row_hi;
   logic              w_col_lo;
   logic              w_col_hi;

   assign w_flush      = (r_state == FLUSH);
   assign w_accept     = i_valid && !w_flush;
   assign w_shift_en   = w_accept || w_flush;
   // Flush cycles push virtual zeros so the bottom rows drain out.
   assign w_shift_data = w_flush ? '0 : i_data;

   raster_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_sr (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_shift_en),
      .i_data (w_shift_data),
      .o_taps (w_taps)
   );

   // Col-first advance of the centre coordinate of the next window.
   always_comb begin
      w_next_row = r_row;
      w_next_col = r_col + RC_ONE;
      if (r_col == RC_EDGE) begin
         w_next_col = '0;
         w_next_row = r_row + RC_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_fcnt  <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         // Coordinates return to 0 once the last window has been shown.
         if (r_done) begin
            r_row <= '0;
            r_col <= '0;
         end
         case (r_state)
            IDLE: begin
               if (i_valid) begin
                  r_cnt   <= C_ONE;
                  r_state <= FILL;
               end
            end
            FILL: begin
               if (i_valid) begin
                  r_cnt <= r_cnt + C_ONE;
                  // First window keeps centre (0,0), so no coordinate advance here.
                  if (r_cnt == P_FIRST) begin
                     r_valid <= 1'b1;
                     r_state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (i_valid) begin
                  r_valid <= 1'b1;
                  r_row   <= w_next_row;
                  r_col   <= w_next_col;
                  if (r_cnt == P_LAST) begin
                     r_cnt   <= '0;
                     r_fcnt  <= '0;
                     r_state <= FLUSH;
                  end else begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
            end
            FLUSH: begin
               r_valid <= 1'b1;
               r_row   <= w_next_row;
               r_col   <= w_next_col;
               r_fcnt  <= r_fcnt + C_ONE;
               if (r_fcnt == FL_LAST) begin
                  r_done  <= 1'b1;
                  r_fcnt  <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Border mask from the centre coordinate; this also hides pixels that the
   // raster order wraps in from the neighbouring row or the previous frame.
   assign w_row_lo = (r_row == '0);
   assign w_row_hi = (r_row == RC_EDGE);
   assign w_col_lo = (r_col == '0);
   assign w_col_hi = (r_col == RC_EDGE);

   for (genvar gi = 0; gi < 3; gi++) begin : g_mrow
      for (genvar gj = 0; gj < 3; gj++) begin : g_mcol
         logic w_kill;
         assign w_kill = ((gi == 0) && w_row_lo) || ((gi == 2) && w_row_hi) ||
                         ((gj == 0) && w_col_lo) || ((gj == 2) && w_col_hi);
         assign w_masked[DATA_WIDTH*(3*gi+gj) +: DATA_WIDTH] =
            w_kill ? '0 : w_taps[DATA_WIDTH*(3*gi+gj) +: DATA_WIDTH];
      end
   end

   assign o_valid  = r_valid;
   assign o_window = r_valid ? w_masked : '0;
   assign o_row    = r_row;
   assign o_col    = r_col;
   assign o_done   = r_done;
   assign o_busy   = w_flush;

`ifdef WINGEN_OVERRUN_CHECK_EN
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_flush && i_valid) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_overrun = r_overrun;
`else
   assign o_overrun = 1'b0;
`endif

endmodule
